// File: rtl/spdif_pulse_classifier_if.sv
// spdif_pulse_classifier_if: line input and classified-symbol outputs of the pulse classifier.
interface spdif_pulse_classifier_if #(
  parameter int CNT_W = 8
);
  logic             spdif_i;
  logic [1:0]       sym_o;
  logic             sym_vld_o;
  logic             err_o;
  logic             locked_o;
  logic [CNT_W-1:0] unit_o;
  modport master (input spdif_i, output sym_o, sym_vld_o, err_o, locked_o, unit_o);
  modport slave (output spdif_i, input sym_o, sym_vld_o, err_o, locked_o, unit_o);
endinterface

// File: rtl/spdif_pulse_classifier.sv
// spdif_pulse_classifier: measures biphase-mark pulse widths, self-calibrates the unit T and classifies widths as 1T/2T/3T.
module spdif_pulse_classifier #(
  parameter int CNT_W        = 8,
  parameter int SYNC_STAGES  = 3,
  parameter int CAL_EDGES    = 64,
  parameter int MIN_UNIT     = 2,
  parameter int LOCK_ERR_MAX = 4
) (
  input logic clk_i,
  input logic rst_i,
  spdif_pulse_classifier_if.master bus
);
  localparam int EW = $clog2(CAL_EDGES + 1);
  localparam int RW = $clog2(LOCK_ERR_MAX + 1);
  localparam int BW = CNT_W + 2;
  typedef enum logic {CAL, LOCKED} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic strobe, first, meas, sat, win_done, lock_ok, lose;
  logic is_s, is_m, is_l, is_err;
  logic [CNT_W-1:0] cnt, min_w, min_nxt;
  logic [EW-1:0] edge_cnt;
  logic [RW-1:0] err_run;
  logic [BW-1:0] t, h, b0, b1, b2, b3, wx;
  assign meas     = strobe && !first;
  assign sat      = &cnt;
  assign min_nxt  = (cnt < min_w) ? cnt : min_w;
  assign win_done = (state == CAL) && meas && (edge_cnt == EW'(CAL_EDGES - 1));
  assign lock_ok  = min_nxt >= CNT_W'(MIN_UNIT);
  assign lose     = (state == LOCKED) && (err_run == RW'(LOCK_ERR_MAX));
  // Widened by two bits so 3T+T/2 cannot wrap for any unit value
  assign t  = BW'(bus.unit_o);
  assign h  = t >> 1;
  assign b0 = t - h;
  assign b1 = t + h;
  assign b2 = (t << 1) + h;
  assign b3 = (t << 1) + t + h;
  assign wx = BW'(cnt);
  assign is_s   = (wx >= b0) && (wx < b1);
  assign is_m   = (wx >= b1) && (wx < b2);
  assign is_l   = (wx >= b2) && (wx < b3);
  assign is_err = sat || !(is_s || is_m || is_l);
  assign bus.locked_o = (state == LOCKED);
  always_comb begin
    state_nxt = state;
    if (win_done && lock_ok) state_nxt = LOCKED;
    if (lose) state_nxt = CAL;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= CAL;
    else state <= state_nxt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync          <= '0;
      strobe        <= 1'b0;
      cnt           <= '0;
      first         <= 1'b1;
      min_w         <= '1;
      edge_cnt      <= '0;
      err_run       <= '0;
      bus.unit_o    <= '0;
      bus.sym_o     <= 2'd0;
      bus.sym_vld_o <= 1'b0;
      bus.err_o     <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], bus.spdif_i};
      strobe        <= sync[SYNC_STAGES-1] ^ sync[SYNC_STAGES-2];
      cnt           <= strobe ? CNT_W'(1) : sat ? cnt : cnt + 1'b1;
      bus.sym_vld_o <= 1'b0;
      bus.err_o     <= 1'b0;
      if (strobe) first <= 1'b0;
      if (lose) begin
        first    <= 1'b1;
        min_w    <= '1;
        edge_cnt <= '0;
        err_run  <= '0;
      end else if (state == CAL && meas) begin
        min_w    <= win_done ? '1 : min_nxt;
        edge_cnt <= win_done ? '0 : edge_cnt + 1'b1;
        if (win_done && lock_ok) begin
          bus.unit_o <= min_nxt;
          err_run    <= '0;
        end
      end else if (state == LOCKED && meas) begin
        bus.sym_vld_o <= !is_err;
        bus.err_o     <= is_err;
        if (!is_err) bus.sym_o <= is_s ? 2'd0 : is_m ? 2'd1 : 2'd2;
        err_run <= is_err ? err_run + 1'b1 : '0;
      end
    end
  end
endmodule

// File: tb/tb_spdif_pulse_classifier.sv
// tb_spdif_pulse_classifier: directed scenarios for calibration, classification, lock loss, reset and saturation.
module tb_spdif_pulse_classifier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tog = 0;
  int ev_q[$];
  spdif_pulse_classifier_if #(.CNT_W(8)) bus ();
  spdif_pulse_classifier dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Event log: 0/1/2 = classified symbol, 3 = error strobe
  always @(negedge clk) begin
    if (bus.sym_vld_o) ev_q.push_back(int'(bus.sym_o));
    if (bus.err_o) ev_q.push_back(3);
  end
  task automatic flush(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input int w);
    while (cyc - last_tog < w) flush(1);
    bus.spdif_i = ~bus.spdif_i;
    last_tog = cyc;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.spdif_i = 1'b0;
    flush(3);
    checks += 5;
    if (bus.sym_o !== 2'd0) begin errors++; $display("FAIL reset_sym: got %0d expected 0", bus.sym_o); end
    if (bus.sym_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b expected 0", bus.sym_vld_o); end
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", bus.err_o); end
    if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", bus.locked_o); end
    if (bus.unit_o !== 8'd0) begin errors++; $display("FAIL reset_unit: got %0d expected 0", bus.unit_o); end
    rst = 1'b0;
    last_tog = cyc;
    ev_q.delete();
  endtask
  task automatic test_lock;
    int exp_q[$];
    exp_q = '{0, 1, 2};
    repeat (65) pulse(8);
    flush(5);
    checks += 3;
    if (bus.locked_o !== 1'b1) begin errors++; $display("FAIL lock_locked: got %0b expected 1", bus.locked_o); end
    if (bus.unit_o !== 8'd8) begin errors++; $display("FAIL lock_unit: got %0d expected 8", bus.unit_o); end
    if (ev_q.size() != 0) begin errors++; $display("FAIL lock_cal_quiet: got %0d events expected 0", ev_q.size()); end
    pulse(8);
    flush(3);
    checks++;
    if (bus.sym_vld_o !== 1'b0) begin errors++; $display("FAIL latency_early: got vld %0b expected 0", bus.sym_vld_o); end
    flush(1);
    checks += 2;
    if (bus.sym_vld_o !== 1'b1) begin errors++; $display("FAIL latency_vld: got %0b expected 1", bus.sym_vld_o); end
    if (bus.sym_o !== 2'd0) begin errors++; $display("FAIL latency_sym: got %0d expected 0", bus.sym_o); end
    pulse(16);
    pulse(24);
    flush(5);
    checks++;
    if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL lock_seq_len: got %0d expected %0d", ev_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_q[i] != exp_q[i]) begin errors++; $display("FAIL lock_seq[%0d]: got %0d expected %0d", i, ev_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_boundaries;
    int widths[9];
    int exp_q[$];
    widths = '{8, 3, 4, 11, 12, 19, 20, 27, 28};
    exp_q = '{0, 3, 0, 0, 1, 1, 2, 2, 3, 0};
    ev_q.delete();
    foreach (widths[i]) pulse(widths[i]);
    pulse(8);
    flush(5);
    checks++;
    if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL bound_len: got %0d expected %0d", ev_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_q[i] != exp_q[i]) begin errors++; $display("FAIL bound[%0d]: got %0d expected %0d", i, ev_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_lock_loss;
    int exp_q[$];
    exp_q = '{0, 3, 3, 3, 3};
    ev_q.delete();
    pulse(8);
    repeat (4) pulse(40);
    flush(4);
    checks += 2;
    if (bus.err_o !== 1'b1) begin errors++; $display("FAIL loss_err4: got %0b expected 1", bus.err_o); end
    if (bus.locked_o !== 1'b1) begin errors++; $display("FAIL loss_still_locked: got %0b expected 1", bus.locked_o); end
    flush(1);
    checks++;
    if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL loss_unlocked: got %0b expected 0", bus.locked_o); end
    checks++;
    if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL loss_len: got %0d expected %0d", ev_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_q[i] != exp_q[i]) begin errors++; $display("FAIL loss[%0d]: got %0d expected %0d", i, ev_q[i], exp_q[i]); end
    end
    ev_q.delete();
    repeat (65) pulse(8);
    flush(5);
    checks += 3;
    if (bus.locked_o !== 1'b1) begin errors++; $display("FAIL relock_locked: got %0b expected 1", bus.locked_o); end
    if (bus.unit_o !== 8'd8) begin errors++; $display("FAIL relock_unit: got %0d expected 8", bus.unit_o); end
    if (ev_q.size() != 0) begin errors++; $display("FAIL relock_quiet: got %0d events expected 0", ev_q.size()); end
  endtask
  task automatic test_reset_midstream;
    pulse(8);
    flush(2);
    rst = 1'b1;
    bus.spdif_i = 1'b0;
    flush(1);
    checks += 5;
    if (bus.sym_o !== 2'd0) begin errors++; $display("FAIL mid_rst_sym: got %0d expected 0", bus.sym_o); end
    if (bus.sym_vld_o !== 1'b0) begin errors++; $display("FAIL mid_rst_vld: got %0b expected 0", bus.sym_vld_o); end
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %0b expected 0", bus.err_o); end
    if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL mid_rst_locked: got %0b expected 0", bus.locked_o); end
    if (bus.unit_o !== 8'd0) begin errors++; $display("FAIL mid_rst_unit: got %0d expected 0", bus.unit_o); end
    rst = 1'b0;
    last_tog = cyc;
    ev_q.delete();
    repeat (64) pulse(8);
    flush(5);
    checks++;
    if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL mid_early_lock: got %0b expected 0", bus.locked_o); end
    pulse(8);
    flush(5);
    checks += 3;
    if (bus.locked_o !== 1'b1) begin errors++; $display("FAIL mid_relock: got %0b expected 1", bus.locked_o); end
    if (bus.unit_o !== 8'd8) begin errors++; $display("FAIL mid_unit: got %0d expected 8", bus.unit_o); end
    if (ev_q.size() != 0) begin errors++; $display("FAIL mid_quiet: got %0d events expected 0", ev_q.size()); end
  endtask
  task automatic test_bad_window;
    rst = 1'b1;
    bus.spdif_i = 1'b0;
    flush(2);
    rst = 1'b0;
    last_tog = cyc;
    pulse(8);
    repeat (62) pulse(8);
    pulse(1);
    pulse(8);
    flush(5);
    checks += 2;
    if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL bad_win_locked: got %0b expected 0", bus.locked_o); end
    if (bus.unit_o !== 8'd0) begin errors++; $display("FAIL bad_win_unit: got %0d expected 0", bus.unit_o); end
    repeat (63) pulse(6);
    flush(5);
    checks++;
    if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL win6_early: got %0b expected 0", bus.locked_o); end
    pulse(6);
    flush(5);
    checks += 2;
    if (bus.locked_o !== 1'b1) begin errors++; $display("FAIL win6_locked: got %0b expected 1", bus.locked_o); end
    if (bus.unit_o !== 8'd6) begin errors++; $display("FAIL win6_unit: got %0d expected 6", bus.unit_o); end
  endtask
  task automatic test_saturation;
    ev_q.delete();
    pulse(12);
    flush(5);
    checks++;
    if (ev_q.size() != 1 || ev_q[0] != 1) begin errors++; $display("FAIL sat_pre_mid: got %0d events expected one mid", ev_q.size()); end
    ev_q.delete();
    flush(300);
    checks += 2;
    if (ev_q.size() != 0) begin errors++; $display("FAIL sat_quiet: got %0d events expected 0", ev_q.size()); end
    if (dut.cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d expected 255", dut.cnt); end
    bus.spdif_i = ~bus.spdif_i;
    last_tog = cyc;
    flush(3);
    checks++;
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL sat_err_early: got %0b expected 0", bus.err_o); end
    flush(1);
    checks += 3;
    if (bus.err_o !== 1'b1) begin errors++; $display("FAIL sat_err: got %0b expected 1", bus.err_o); end
    if (bus.sym_vld_o !== 1'b0) begin errors++; $display("FAIL sat_vld: got %0b expected 0", bus.sym_vld_o); end
    if (bus.sym_o !== 2'd1) begin errors++; $display("FAIL sat_sym_hold: got %0d expected 1", bus.sym_o); end
    flush(1);
    checks += 2;
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL sat_err_width: got %0b expected 0", bus.err_o); end
    if (bus.locked_o !== 1'b1) begin errors++; $display("FAIL sat_locked: got %0b expected 1", bus.locked_o); end
  endtask
  initial begin
    bus.spdif_i = 1'b0;
    test_reset();
    test_lock();
    test_boundaries();
    test_lock_loss();
    test_reset_midstream();
    test_bad_window();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
